sram_stall_mem: RTL and testbench
=================================

SRAM_STALL_MEM -- requirements
Module: sram_stall_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the word-index width (2^ADDR_W 32-bit words).
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..15, giving the stall cycles per request.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sram_en, input, 1 bit: request valid.
REQ-006 The block SHALL have port sram_wen, input, 4 bits: byte write enables; 4'b0000 means read, any other value means write.
REQ-007 The block SHALL have port sram_addr, input, 32 bits: byte address.
REQ-008 The block SHALL have port sram_wdata, input, 32 bits: write data.
REQ-009 The block SHALL have port sram_rdata, output, 32 bits: read data.
REQ-010 The block SHALL have port stall, output, 1 bit: requester must hold its request and pipeline while high.

Function
REQ-011 The block SHALL implement three states: IDLE, WAIT and DONE.
REQ-012 Word index SHALL be sram_addr[ADDR_W+1:2]; sram_addr[1:0] and bits above ADDR_W+1 SHALL be ignored; there SHALL be no out-of-range error.
REQ-013 In IDLE with sram_en=1 and rst=0, the block SHALL accept the request and register sram_wen, word index and sram_wdata.
REQ-014 stall SHALL be combinational: 1 when (IDLE and sram_en and not rst) or in WAIT; 0 in DONE and when idle.
REQ-015 For a request accepted in cycle T, stall SHALL be 1 in exactly cycles T..T+LATENCY-1, and the block SHALL be in DONE with stall=0 in cycle T+LATENCY.
REQ-016 Input changes on sram_en, sram_wen, sram_addr and sram_wdata after acceptance SHALL be ignored until the block returns to IDLE.
REQ-017 The WAIT countdown SHALL use a 4-bit counter; when LATENCY=1 the block SHALL go from IDLE directly to DONE.
REQ-018 For a read, memory SHALL be read at the rising edge ending cycle T+LATENCY-1, and sram_rdata SHALL be valid from cycle T+LATENCY onward.
REQ-019 sram_rdata SHALL hold its value until the next read completes; writes SHALL NOT change sram_rdata.
REQ-020 For a write, the edge ending cycle T+LATENCY-1 SHALL update only the byte lanes with sram_wen[i]=1 (lane i = bits 8i+7:8i); the other lanes SHALL keep their value.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-022 A request that is still present in the cycle after DONE SHALL be treated as a new request (it re-executes); back-to-back requests SHALL therefore see a one-cycle gap with stall=0 (the DONE cycle).
REQ-023 A read from a word SHALL return the value of every write to that word completed earlier.
REQ-024 Memory contents SHALL be uninitialised, with no preload and no clear.

Reset
REQ-025 While rst=1, stall SHALL be 0, the state SHALL go to IDLE at the clock edge, no request SHALL be accepted, and sram_rdata SHALL be 32'h0 after the edge.
REQ-026 Reset asserted in WAIT SHALL abort the request with no memory write, and the block SHALL be in IDLE with stall=0 in the next cycle.
REQ-027 Memory contents SHALL NOT be affected by reset.
REQ-028 After rst falls, a request presented in the first cycle SHALL be accepted normally.

Verification
REQ-029 Bench SHALL check: LATENCY=2, write sram_wen=4'hF, addr=0x10, data=0xDEADBEEF, then read addr=0x10 -> stall high 2 cycles per request, sram_rdata=0xDEADBEEF in the read's DONE cycle.
REQ-030 Bench SHALL check: byte write sram_wen=4'b0010, data=0x0000AB00 to a word holding 0x11223344, then read -> 0x1122AB44.
REQ-031 Bench SHALL check: change sram_addr and sram_wdata mid-WAIT -> original address and data used, and the memory word at the new address is unchanged.
REQ-032 Bench SHALL check: LATENCY=1, continuous sram_en reads -> stall pattern 1,0,1,0...; LATENCY=15 -> 15 stall cycles then 1 low cycle.
REQ-033 Bench SHALL check: rst asserted during the WAIT of a write to 0x20 holding 0x55 -> next cycle IDLE, stall=0, sram_rdata=0, and a later read of 0x20 returns 0x55.
REQ-034 Bench SHALL check: sram_addr=0x0000_1004 vs 0x0000_0004 with ADDR_W=10 -> same word (aliasing), and address bits [1:0]=2'b11 ignored.

Source files
------------

// File: rtl/sram_stall_mem.sv
// Word-addressed SRAM model with a fixed, parameterised stall per request.
// Each request is captured on acceptance and executed at the end of its last stall cycle.
module sram_stall_mem #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bit         SINGLE_CYCLE = (LATENCY == 1);
  localparam logic [3:0] WAIT_LOAD    = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nxt_s;
  logic [3:0]          wen_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [31:0]         wdata_r;
  logic [31:0]         rdata_r;
  logic                accept_s;
  logic                op_fire_s;
  logic [3:0]          op_wen_s;
  logic [ADDR_W-1:0]   op_idx_s;
  logic [31:0]         op_wdata_s;
  logic [ADDR_W-1:0]   addr_idx_s;
  logic                unused_addr_s;

  logic [31:0] mem_r [2**ADDR_W];

  assign addr_idx_s    = sram_addr[ADDR_W+1:2];
  assign unused_addr_s = ^{sram_addr[31:ADDR_W+2], sram_addr[1:0]};

  // With a single-cycle latency the operation fires on the acceptance edge, so use live inputs.
  assign op_wen_s   = accept_s ? sram_wen   : wen_r;
  assign op_idx_s   = accept_s ? addr_idx_s : idx_r;
  assign op_wdata_s = accept_s ? sram_wdata : wdata_r;

  assign stall      = !rst && (((state_r == IDLE) && sram_en) || (state_r == WAIT));
  assign sram_rdata = rdata_r;

  // Next-state, countdown and operation-fire decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    op_fire_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sram_en) begin
          accept_s = 1'b1;
          if (SINGLE_CYCLE) begin
            state_nxt_s = DONE;
            op_fire_s   = 1'b1;
          end else begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = DONE;
          op_fire_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    // Reset aborts any pending request before it can touch memory.
    if (rst) begin
      state_nxt_s = IDLE;
      accept_s    = 1'b0;
      op_fire_s   = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State, request capture and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      wen_r   <= 4'd0;
      idx_r   <= '0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        wen_r   <= sram_wen;
        idx_r   <= addr_idx_s;
        wdata_r <= sram_wdata;
      end
      if (op_fire_s && (op_wen_s == 4'b0000)) begin
        rdata_r <= mem_r[op_idx_s];
      end
    end
  end

  // Storage array: byte-lane writes only, never reset or preloaded.
  always_ff @(posedge clk) begin
    if (op_fire_s && (op_wen_s != 4'b0000)) begin
      for (int i = 0; i < 4; i++) begin
        if (op_wen_s[i]) begin
          mem_r[op_idx_s][8*i +: 8] <= op_wdata_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_stall_mem.sv
// Directed self-checking bench for sram_stall_mem at LATENCY 2, 1 and 15.
module tb_sram_stall_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en2 = 1'b0, en1 = 1'b0, en15 = 1'b0;
  logic [3:0]  sram_wen   = 4'h0;
  logic [31:0] sram_addr  = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] rdata2, rdata1, rdata15;
  logic        stall2, stall1, stall15;
  logic [31:0] rd;
  int          nvec  = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  sram_stall_mem #(.ADDR_W(10), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .sram_en(en2), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(rdata2), .stall(stall2));
  sram_stall_mem #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .sram_en(en1), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(rdata1), .stall(stall1));
  sram_stall_mem #(.ADDR_W(10), .LATENCY(15)) dut15 (
    .clk(clk), .rst(rst), .sram_en(en15), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(rdata15), .stall(stall15));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One LATENCY=2 request: stall 1,1 then 0 in DONE; returns rdata seen in DONE.
  task automatic req2(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                      input string tag, output logic [31:0] done_rd);
    en2 = 1'b1; sram_wen = w; sram_addr = a; sram_wdata = d;
    @(negedge clk); chk({tag, "_stall_t0"}, {31'd0, stall2}, 32'd1);
    tick();
    @(negedge clk); chk({tag, "_stall_t1"}, {31'd0, stall2}, 32'd1);
    tick();
    en2 = 1'b0;
    @(negedge clk); chk({tag, "_stall_done"}, {31'd0, stall2}, 32'd0);
    done_rd = rdata2;
    tick();
  endtask

  initial begin
    // Reset: no stall, read data cleared
    tick();
    @(negedge clk);
    chk("rst_stall2", {31'd0, stall2}, 32'd0);
    chk("rst_stall1", {31'd0, stall1}, 32'd0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_rdata15", rdata15, 32'h0);
    tick();
    rst = 1'b0;

    // Full write then read back, first request right after reset release
    req2(4'hF, 32'h10, 32'hDEADBEEF, "wr10", rd);
    req2(4'h0, 32'h10, 32'h0, "rd10", rd);
    chk("rd10_data", rd, 32'hDEADBEEF);

    // Single byte-lane write
    req2(4'hF, 32'h40, 32'h11223344, "wr40", rd);
    req2(4'b0010, 32'h40, 32'h0000AB00, "bw40", rd);
    req2(4'h0, 32'h40, 32'h0, "rd40", rd);
    chk("rd40_byte", rd, 32'h1122AB44);

    // Writes leave sram_rdata alone
    req2(4'hF, 32'h50, 32'hAAAA0001, "wr50", rd);
    req2(4'hF, 32'h60, 32'hBBBB0002, "wr60", rd);
    chk("rdata_hold", rdata2, 32'h1122AB44);

    // Inputs changed mid-WAIT are ignored
    en2 = 1'b1; sram_wen = 4'hF; sram_addr = 32'h50; sram_wdata = 32'h12345678;
    @(negedge clk); chk("chg_stall_t0", {31'd0, stall2}, 32'd1);
    tick();
    sram_addr = 32'h60; sram_wdata = 32'hFFFFFFFF; sram_wen = 4'h0;
    @(negedge clk); chk("chg_stall_t1", {31'd0, stall2}, 32'd1);
    tick();
    en2 = 1'b0;
    @(negedge clk); chk("chg_stall_done", {31'd0, stall2}, 32'd0);
    tick();
    req2(4'h0, 32'h50, 32'h0, "rd50", rd);
    chk("rd50_orig", rd, 32'h12345678);
    req2(4'h0, 32'h60, 32'h0, "rd60", rd);
    chk("rd60_untouched", rd, 32'hBBBB0002);

    // Address aliasing: bit 12 and bits [1:0] ignored
    req2(4'hF, 32'h0000_1004, 32'hCAFEF00D, "wr1004", rd);
    req2(4'h0, 32'h0000_0007, 32'h0, "rd0007", rd);
    chk("alias_data", rd, 32'hCAFEF00D);

    // Reset during WAIT aborts the write
    req2(4'hF, 32'h20, 32'h00000055, "wr20", rd);
    req2(4'h0, 32'h20, 32'h0, "rd20a", rd);
    chk("rd20_pre", rd, 32'h00000055);
    en2 = 1'b1; sram_wen = 4'hF; sram_addr = 32'h20; sram_wdata = 32'hFFFFFFFF;
    @(negedge clk); chk("abort_stall_t0", {31'd0, stall2}, 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk); chk("abort_stall_rst", {31'd0, stall2}, 32'd0);
    tick();
    rst = 1'b0; en2 = 1'b0;
    @(negedge clk);
    chk("abort_stall_idle", {31'd0, stall2}, 32'd0);
    chk("abort_rdata", rdata2, 32'h0);
    tick();
    req2(4'h0, 32'h20, 32'h0, "rd20b", rd);
    chk("rd20_kept", rd, 32'h00000055);

    // LATENCY=1: write then continuous reads, stall alternates 1,0
    en1 = 1'b1; sram_wen = 4'hF; sram_addr = 32'h10; sram_wdata = 32'h0BADCAFE;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("lat1_stall_%0d", i), {31'd0, stall1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 3) chk("lat1_rdata", rdata1, 32'h0BADCAFE);
      tick();
      sram_wen = 4'h0;
    end
    en1 = 1'b0;

    // LATENCY=15: 15 stall cycles, one low DONE cycle, then held request re-executes
    en15 = 1'b1; sram_wen = 4'hF; sram_addr = 32'h30; sram_wdata = 32'h5A5A1234;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("lat15_stall_%0d", i), {31'd0, stall15}, (i == 15) ? 32'd0 : 32'd1);
      tick();
    end
    en15 = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    en15 = 1'b1; sram_wen = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        chk("lat15_done_stall", {31'd0, stall15}, 32'd0);
        chk("lat15_rdata", rdata15, 32'h5A5A1234);
      end
      tick();
      if (i == 14) en15 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
